// File: rtl/output_arbiter_pkg.sv
// Shared definitions for output_arbiter and its round-robin picker:
// FSM state encodings and the channel/data defaults shared with output_filter.
package output_arbiter_pkg;

    localparam int OPA_N_CHAN = 8;
    localparam int OPA_W_CHAN = 5;
    localparam int OPA_W_DATA = 16;
    localparam int OPA_W_CNT  = 16;

    typedef enum logic [0:0] {
        OPA_IDLE  = 1'b0,
        OPA_ISSUE = 1'b1
    } opa_state_e;

endpackage

// File: rtl/output_arbiter_if.sv
// Bus between output_filter, output_arbiter and the downstream instruction controller.
// Handshake: dv_in has no backpressure; an instruction transfers on a clk_in edge where
// instr_valid && instr_ready, and instr_valid/instr_chan/instr_data hold while valid && !ready.
interface output_arbiter_if #(
    parameter int W_CHAN = 5,
    parameter int W_DATA = 16,
    parameter int W_CNT  = 16
) ();

    logic              dv_in;
    logic [W_CHAN-1:0] chan_in;
    logic [W_DATA-1:0] data_in;
    logic              instr_ready;
    logic              instr_valid;
    logic [W_CHAN-1:0] instr_chan;
    logic [W_DATA-1:0] instr_data;
    logic [W_CNT-1:0]  ovwr_count;

    modport master (
        output dv_in, chan_in, data_in, instr_ready,
        input  instr_valid, instr_chan, instr_data, ovwr_count
    );

    modport slave (
        input  dv_in, chan_in, data_in, instr_ready,
        output instr_valid, instr_chan, instr_data, ovwr_count
    );

endinterface

// File: rtl/output_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending channel at or after i_rr_ptr,
// wrapping at N_CHAN-1. Also used by the DDS-side arbiter.
module output_arbiter_rr_pick
    import output_arbiter_pkg::*;
#(
    parameter int N_CHAN = OPA_N_CHAN,
    parameter int W_CHAN = OPA_W_CHAN
) (
    input  logic [N_CHAN-1:0] i_pend,
    input  logic [W_CHAN-1:0] i_rr_ptr,
    output logic              o_grant_valid,
    output logic [W_CHAN-1:0] o_grant_chan
);

    logic [N_CHAN-1:0] w_rot;
    logic [W_CHAN:0]   w_sum;

    // Rotate so bit k of w_rot is channel (i_rr_ptr + k) mod N_CHAN.
    assign w_rot = N_CHAN'({i_pend, i_pend} >> i_rr_ptr);

    // Walk from the far end so the nearest pending channel is the last assignment.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_chan  = '0;
        w_sum         = '0;
        for (int k = N_CHAN - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_rr_ptr} + (W_CHAN + 1)'(k);
                if (w_sum >= (W_CHAN + 1)'(N_CHAN)) begin
                    w_sum = w_sum - (W_CHAN + 1)'(N_CHAN);
                end
                o_grant_valid = 1'b1;
                o_grant_chan  = w_sum[W_CHAN-1:0];
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Coalescing per-channel holding store with round-robin issue over valid/ready.
// Optional saturating overwrite counter enabled by defining OPA_OVWR_CNT_EN.
module output_arbiter
    import output_arbiter_pkg::*;
#(
    parameter int W_CHAN = OPA_W_CHAN,
    parameter int N_CHAN = OPA_N_CHAN,
    parameter int W_DATA = OPA_W_DATA,
    parameter int W_CNT  = OPA_W_CNT
) (
    input  logic                clk_in,
    input  logic                rst_in,
    output_arbiter_if.slave     bus,
    output opa_state_e          o_dbg_state
);

    opa_state_e        r_state;
    opa_state_e        w_state_nxt;
    logic [W_DATA-1:0] r_data_mem [N_CHAN];
    logic [N_CHAN-1:0] r_pend;
    logic [W_CHAN-1:0] r_rr_ptr;
    logic [W_CHAN-1:0] r_instr_chan;
    logic [W_DATA-1:0] r_instr_data;

    logic              w_grant_valid;
    logic [W_CHAN-1:0] w_grant_chan;
    logic [W_DATA-1:0] w_grant_data;
    logic              w_cap;
    logic              w_xfer;
    logic              w_grant;
    logic [N_CHAN-1:0] w_cap_onehot;
    logic [N_CHAN-1:0] w_grant_onehot;
    logic [N_CHAN-1:0] w_pend_nxt;

    output_arbiter_rr_pick #(
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN)
    ) u_rr_pick (
        .i_pend        (r_pend),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_chan  (w_grant_chan)
    );

    assign w_cap   = bus.dv_in && ({1'b0, bus.chan_in} < (W_CHAN + 1)'(N_CHAN));
    assign w_xfer  = (r_state == OPA_ISSUE) && bus.instr_ready;
    assign w_grant = w_grant_valid && ((r_state == OPA_IDLE) || w_xfer);

    always_comb begin
        w_cap_onehot   = '0;
        w_grant_onehot = '0;
        w_grant_data   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            w_cap_onehot[i]   = w_cap && (bus.chan_in == W_CHAN'(i));
            w_grant_onehot[i] = w_grant && (w_grant_chan == W_CHAN'(i));
            if (w_grant_chan == W_CHAN'(i)) begin
                w_grant_data = r_data_mem[i];
            end
        end
    end

    // A capture landing on the channel being granted keeps it pending.
    assign w_pend_nxt = (r_pend & ~w_grant_onehot) | w_cap_onehot;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= OPA_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OPA_IDLE:  if (w_grant_valid) w_state_nxt = OPA_ISSUE;
            OPA_ISSUE: if (w_xfer && !w_grant_valid) w_state_nxt = OPA_IDLE;
            default:   w_state_nxt = OPA_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_valid = (r_state == OPA_ISSUE);
        o_dbg_state     = r_state;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend       <= '0;
            r_rr_ptr     <= '0;
            r_instr_chan <= '0;
            r_instr_data <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_grant) begin
                r_instr_chan <= w_grant_chan;
                r_instr_data <= w_grant_data;
                r_rr_ptr     <= (w_grant_chan == W_CHAN'(N_CHAN - 1)) ? '0
                                                                       : w_grant_chan + W_CHAN'(1);
            end
        end
    end

    // Held values survive reset; only the pending flags are cleared.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (w_cap_onehot[i]) begin
                r_data_mem[i] <= bus.data_in;
            end
        end
    end

    assign bus.instr_chan = r_instr_chan;
    assign bus.instr_data = r_instr_data;

`ifdef OPA_OVWR_CNT_EN
    logic [W_CNT-1:0] r_ovwr_count;
    logic             w_ovwr;

    assign w_ovwr = |(w_cap_onehot & r_pend & ~w_grant_onehot);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ovwr_count <= '0;
        end else if (w_ovwr && (r_ovwr_count != {W_CNT{1'b1}})) begin
            r_ovwr_count <= r_ovwr_count + W_CNT'(1);
        end
    end

    assign bus.ovwr_count = r_ovwr_count;
`else
    assign bus.ovwr_count = {W_CNT{1'b0}};
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: directed scenarios with an expected issue queue, then
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_output_arbiter;
    import output_arbiter_pkg::*;

    localparam int N_CHAN = 8;
    localparam int W_CHAN = 5;
    localparam int W_DATA = 16;
    localparam int W_CNT  = 16;
    localparam int W_ENT  = W_CHAN + W_DATA;

    logic       clk_in = 1'b0;
    logic       rst_in;
    opa_state_e dbg_state;

    always #5 clk_in = ~clk_in;

    output_arbiter_if #(.W_CHAN(W_CHAN), .W_DATA(W_DATA), .W_CNT(W_CNT)) bus ();

    output_arbiter #(
        .W_CHAN (W_CHAN),
        .N_CHAN (N_CHAN),
        .W_DATA (W_DATA),
        .W_CNT  (W_CNT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Behavioural model: latest value and pending flag per channel, one held instruction.
    logic [W_DATA-1:0] m_mem [N_CHAN];
    bit                m_pend [N_CHAN];
    int                m_ptr;
    bit                m_valid;
    int                m_chan;
    logic [W_DATA-1:0] m_data;
    longint            m_cnt;

    logic [W_ENT-1:0] exp_q[$];
    logic [W_ENT-1:0] got_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit xfer;
        int g;
        int ci;
        if (rst_in) begin
            m_valid = 0; m_chan = 0; m_data = '0; m_ptr = 0; m_cnt = 0;
            for (int i = 0; i < N_CHAN; i++) m_pend[i] = 0;
            return;
        end
        xfer = m_valid && (bus.instr_ready === 1'b1);
        g = -1;
        for (int k = 0; k < N_CHAN; k++) begin
            int c;
            c = (m_ptr + k) % N_CHAN;
            if (g < 0 && m_pend[c]) g = c;
        end
        if ((!m_valid || xfer) && g >= 0) begin
            m_valid = 1; m_chan = g; m_data = m_mem[g];
            m_pend[g] = 0; m_ptr = (g + 1) % N_CHAN;
        end else if (xfer) begin
            m_valid = 0;
        end
        ci = int'(bus.chan_in);
        if (bus.dv_in && ci < N_CHAN) begin
`ifdef OPA_OVWR_CNT_EN
            if (m_pend[ci] && m_cnt < ((longint'(1) << W_CNT) - 1)) m_cnt++;
`endif
            m_mem[ci]  = bus.data_in;
            m_pend[ci] = 1;
        end
    endtask

    task automatic cycle();
        if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1)
            got_q.push_back({bus.instr_chan, bus.instr_data});
        @(posedge clk_in);
        model_step();
        #1;
        check("valid", 64'(bus.instr_valid), 64'(m_valid));
        check("chan",  64'(bus.instr_chan),  64'(m_chan));
        check("data",  64'(bus.instr_data),  64'(m_data));
        check("ovwr",  64'(bus.ovwr_count),  64'(m_cnt));
    endtask

    task automatic wr(input int ch, input logic [W_DATA-1:0] d);
        bus.dv_in = 1'b1; bus.chan_in = W_CHAN'(ch); bus.data_in = d;
        cycle();
        bus.dv_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_in = 1'b1; bus.dv_in = 1'b0; bus.instr_ready = 1'b0;
        idle(2);
        rst_in = 1'b0;
    endtask

    task automatic expect_issue(input int ch, input logic [W_DATA-1:0] d);
        exp_q.push_back({W_CHAN'(ch), d});
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst_in = 1'b1; bus.dv_in = 1'b0; bus.chan_in = '0; bus.data_in = '0; bus.instr_ready = 1'b0;
        m_valid = 0; m_chan = 0; m_data = '0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < N_CHAN; i++) m_pend[i] = 0;

        // Reset state
        idle(2);
        check("rst_valid", 64'(bus.instr_valid), 64'(0));
        check("rst_chan",  64'(bus.instr_chan),  64'(0));
        check("rst_data",  64'(bus.instr_data),  64'(0));
        check("rst_ovwr",  64'(bus.ovwr_count),  64'(0));
        rst_in = 1'b0;

        // Single write: valid two cycles after capture, low the cycle after transfer
        bus.instr_ready = 1'b1;
        wr(3, 16'h1234);
        cycle();
        check("single_valid_t2", 64'(bus.instr_valid), 64'(1));
        check("single_chan_t2",  64'(bus.instr_chan),  64'(3));
        check("single_data_t2",  64'(bus.instr_data),  64'h1234);
        cycle();
        check("single_valid_t3", 64'(bus.instr_valid), 64'(0));
        expect_issue(3, 16'h1234);
        drain_check("single");

        // Coalescing behind an in-flight chan 0
        do_reset();
        wr(0, 16'h00AA); cycle();
        wr(2, 16'd10); wr(2, 16'd20); wr(2, 16'd30);
        idle(2);
`ifdef OPA_OVWR_CNT_EN
        check("coal_ovwr", 64'(bus.ovwr_count), 64'(2));
`else
        check("coal_ovwr", 64'(bus.ovwr_count), 64'(0));
`endif
        bus.instr_ready = 1'b1; idle(4); bus.instr_ready = 1'b0;
        expect_issue(0, 16'h00AA); expect_issue(2, 16'd30);
        drain_check("coalesce");

        // Round-robin from pointer 0 (chan 7 in flight), then from pointer 6 (chan 5 in flight)
        do_reset();
        wr(7, 16'd70); cycle();
        wr(0, 16'd1); wr(1, 16'd2); wr(5, 16'd3); wr(7, 16'd4);
        bus.instr_ready = 1'b1; idle(7);
        expect_issue(7, 16'd70); expect_issue(0, 16'd1); expect_issue(1, 16'd2);
        expect_issue(5, 16'd3); expect_issue(7, 16'd4);
        drain_check("rr_ptr0");
        do_reset();
        wr(5, 16'd50); cycle();
        wr(0, 16'd11); wr(1, 16'd12); wr(5, 16'd13); wr(7, 16'd14);
        bus.instr_ready = 1'b1; idle(7);
        expect_issue(5, 16'd50); expect_issue(7, 16'd14); expect_issue(0, 16'd11);
        expect_issue(1, 16'd12); expect_issue(5, 16'd13);
        drain_check("rr_ptr6");

        // Backpressure: chan 4 held stable for 10 cycles while 4 and 6 are rewritten
        do_reset();
        wr(4, 16'hA4A4); cycle();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin bus.dv_in = 1'b1; bus.chan_in = 5'd4; bus.data_in = 16'hB4B4; end
            else if (i == 5) begin bus.dv_in = 1'b1; bus.chan_in = 5'd6; bus.data_in = 16'hC6C6; end
            else bus.dv_in = 1'b0;
            cycle();
            check("bp_valid", 64'(bus.instr_valid), 64'(1));
            check("bp_chan",  64'(bus.instr_chan),  64'(4));
            check("bp_data",  64'(bus.instr_data),  64'hA4A4);
        end
        bus.dv_in = 1'b0;
        bus.instr_ready = 1'b1; idle(5);
        expect_issue(4, 16'hA4A4); expect_issue(6, 16'hC6C6); expect_issue(4, 16'hB4B4);
        drain_check("backpressure");

        // Same-cycle capture and grant on chan 1
        do_reset();
        bus.instr_ready = 1'b1;
        wr(1, 16'h1111); wr(1, 16'h2222);
        idle(4);
        expect_issue(1, 16'h1111); expect_issue(1, 16'h2222);
        drain_check("same_cycle");

        // Illegal channels are dropped
        do_reset();
        bus.instr_ready = 1'b1;
        wr(N_CHAN, 16'hDEAD); wr(31, 16'hBEEF);
        idle(4);
        drain_check("illegal");

        // Reset mid-ISSUE with three pending
        bus.instr_ready = 1'b0;
        wr(2, 16'h0202); cycle();
        wr(3, 16'h0303); wr(4, 16'h0404); wr(5, 16'h0505);
        rst_in = 1'b1; cycle(); rst_in = 1'b0;
        check("rst_mid_valid", 64'(bus.instr_valid), 64'(0));
        bus.instr_ready = 1'b1; idle(10);
        drain_check("rst_mid");

        // Randomized traffic at three backpressure levels
        do_reset();
        for (int p = 0; p < 3; p++) begin
            int rdy_pct;
            rdy_pct = (p == 0) ? 20 : (p == 1) ? 50 : 90;
            repeat (1500) begin
                bus.dv_in       = ($urandom_range(0, 99) < 60);
                bus.chan_in     = W_CHAN'($urandom_range(0, 9));
                bus.data_in     = W_DATA'($urandom);
                bus.instr_ready = ($urandom_range(0, 99) < rdy_pct);
                rst_in          = ($urandom_range(0, 599) == 0);
                cycle();
            end
        end
        rst_in = 1'b0; bus.dv_in = 1'b0;
        got_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
